// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the RISC-V datapath: sequences EXEC, MEM_WAIT and WB
// for one decoded instruction at a time and drives ALU, regfile, PC, memory and GPIO enables.
module multicycle_control_unit #(
  parameter int NUM_GPIO    = 2,
  parameter int MEM_TIMEOUT = 15,
  parameter int CSR_SEL_W   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [2:0]           itype,
  input  logic [3:0]           instr,
  input  logic [CSR_SEL_W-1:0] csr_sel,
  input  logic                 branch_taken,
  input  logic                 mem_ready,
  output logic                 alusrc,
  output logic                 regwrite,
  output logic [1:0]           regsel,
  output logic [3:0]           aluop,
  output logic [NUM_GPIO-1:0]  gpio_we,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 pc_en,
  output logic                 pc_sel,
  output logic                 err
);
  localparam int               CNT_W     = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);
  localparam logic [3:0]       OP_CSRRW  = 4'b1101;
  localparam logic [1:0]       SEL_MEM   = 2'b00;
  localparam logic [1:0]       SEL_IMM   = 2'b01;
  localparam logic [1:0]       SEL_ALU   = 2'b10;

  typedef enum logic [1:0] {IDLE, EXEC, MEM_WAIT, WB} state_e;
  typedef enum logic [2:0] {
    IT_R, IT_I, IT_U, IT_LOAD, IT_STORE, IT_BRANCH, IT_ILL6, IT_ILL7
  } itype_e;

  state_e               state_q, state_d;
  itype_e               itype_q;
  logic [3:0]           instr_q;
  logic [CSR_SEL_W-1:0] csr_sel_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 accept;
  logic                 is_csrrw;
  logic                 csr_in_range;
  logic                 timed_out;

  assign accept       = instr_valid && (state_q == IDLE);
  assign is_csrrw     = (itype_q == IT_R) && (instr_q == OP_CSRRW);
  assign csr_in_range = int'(csr_sel_q) < NUM_GPIO;
  // A same-cycle mem_ready always completes the access instead of aborting it.
  assign timed_out    = (MEM_TIMEOUT != 0) && (cnt_q == CNT_LIMIT) && !mem_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; all control registers get an explicit reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      itype_q   <= IT_R;
      instr_q   <= '0;
      csr_sel_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        itype_q   <= itype_e'(itype);
        instr_q   <= instr;
        csr_sel_q <= csr_sel;
      end
    end
  end

  // NOTE: every output and next-state value is defaulted first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    instr_ready = 1'b0;
    alusrc      = 1'b0;
    regwrite    = 1'b0;
    regsel      = SEL_MEM;
    aluop       = '0;
    gpio_we     = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    pc_en       = 1'b0;
    pc_sel      = 1'b0;
    err         = 1'b0;

    case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = EXEC;
      end

      EXEC: begin
        state_d = IDLE;
        case (itype_q)
          IT_R: begin
            pc_en = 1'b1;
            if (is_csrrw) begin
              if (csr_in_range) gpio_we = NUM_GPIO'(1) << csr_sel_q;
              else              err     = 1'b1;
            end else begin
              aluop    = instr_q;
              regsel   = SEL_ALU;
              regwrite = 1'b1;
            end
          end
          IT_I: begin
            aluop    = instr_q;
            alusrc   = 1'b1;
            regsel   = SEL_ALU;
            regwrite = 1'b1;
            pc_en    = 1'b1;
          end
          IT_U: begin
            regsel   = SEL_IMM;
            regwrite = 1'b1;
            pc_en    = 1'b1;
          end
          IT_LOAD, IT_STORE: begin
            alusrc  = 1'b1;
            mem_req = 1'b1;
            mem_we  = (itype_q == IT_STORE);
            cnt_d   = '0;
            state_d = MEM_WAIT;
          end
          IT_BRANCH: begin
            aluop  = instr_q;
            pc_en  = 1'b1;
            pc_sel = branch_taken;
          end
          default: begin
            err   = 1'b1;
            pc_en = 1'b1;
          end
        endcase
      end

      MEM_WAIT: begin
        alusrc  = 1'b1;
        mem_req = 1'b1;
        mem_we  = (itype_q == IT_STORE);
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        if (mem_ready) begin
          if (itype_q == IT_STORE) begin
            pc_en   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WB;
          end
        end else if (timed_out) begin
          err     = 1'b1;
          state_d = IDLE;
        end
      end

      WB: begin
        regsel   = SEL_MEM;
        regwrite = 1'b1;
        pc_en    = 1'b1;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized scoreboard bench for multicycle_control_unit: the driver pushes the expected
// per-cycle output sequence of each instruction, a monitor pops and compares every cycle.
module tb_multicycle_control_unit;
  localparam int NG    = 3;
  localparam int MT    = 15;
  localparam int CSR_W = 2;

  typedef struct packed {
    logic          instr_ready;
    logic          alusrc;
    logic          regwrite;
    logic [1:0]    regsel;
    logic [3:0]    aluop;
    logic [NG-1:0] gpio_we;
    logic          mem_req;
    logic          mem_we;
    logic          pc_en;
    logic          pc_sel;
    logic          err;
  } outs_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             instr_valid;
  logic             instr_ready;
  logic [2:0]       itype;
  logic [3:0]       instr;
  logic [CSR_W-1:0] csr_sel;
  logic             branch_taken;
  logic             mem_ready;
  logic             alusrc;
  logic             regwrite;
  logic [1:0]       regsel;
  logic [3:0]       aluop;
  logic [NG-1:0]    gpio_we;
  logic             mem_req;
  logic             mem_we;
  logic             pc_en;
  logic             pc_sel;
  logic             err;

  int    checks = 0;
  int    errors = 0;
  int    n_cyc  = 0;
  outs_t exp_q[$];
  outs_t idle_o;

  multicycle_control_unit #(.NUM_GPIO(NG), .MEM_TIMEOUT(MT), .CSR_SEL_W(CSR_W)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .itype(itype), .instr(instr), .csr_sel(csr_sel), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .alusrc(alusrc), .regwrite(regwrite), .regsel(regsel),
    .aluop(aluop), .gpio_we(gpio_we), .mem_req(mem_req), .mem_we(mem_we),
    .pc_en(pc_en), .pc_sel(pc_sel), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic outs_t sample();
    return {instr_ready, alusrc, regwrite, regsel, aluop, gpio_we,
            mem_req, mem_we, pc_en, pc_sel, err};
  endfunction

  // Reference model: expected outputs for every busy cycle of one instruction.
  // n_wait = MEM_WAIT cycles up to and including mem_ready; 0 means memory never answers.
  task automatic model(input logic [2:0] it, input logic [3:0] op, input logic [CSR_W-1:0] sel,
                       input logic bt, input int n_wait, output int len);
    outs_t o, m;
    o   = '0;
    len = 0;
    case (it)
      3'd0: begin
        o.pc_en = 1'b1;
        if (op == 4'd13) begin
          if (int'(sel) < NG) o.gpio_we[sel] = 1'b1;
          else                o.err          = 1'b1;
        end else begin
          o.aluop = op; o.regsel = 2'b10; o.regwrite = 1'b1;
        end
        exp_q.push_back(o); len++;
      end
      3'd1: begin
        o.aluop = op; o.alusrc = 1'b1; o.regsel = 2'b10; o.regwrite = 1'b1; o.pc_en = 1'b1;
        exp_q.push_back(o); len++;
      end
      3'd2: begin
        o.regsel = 2'b01; o.regwrite = 1'b1; o.pc_en = 1'b1;
        exp_q.push_back(o); len++;
      end
      3'd3, 3'd4: begin
        m = '0; m.alusrc = 1'b1; m.mem_req = 1'b1; m.mem_we = (it == 3'd4);
        exp_q.push_back(m); len++;
        if (n_wait > 0) begin
          for (int k = 1; k < n_wait; k++) begin exp_q.push_back(m); len++; end
          o = m; o.pc_en = (it == 3'd4);
          exp_q.push_back(o); len++;
          if (it == 3'd3) begin
            o = '0; o.regsel = 2'b00; o.regwrite = 1'b1; o.pc_en = 1'b1;
            exp_q.push_back(o); len++;
          end
        end else begin
          for (int k = 1; k <= MT; k++) begin exp_q.push_back(m); len++; end
          o = m; o.err = 1'b1;
          exp_q.push_back(o); len++;
        end
      end
      3'd5: begin
        o.aluop = op; o.pc_en = 1'b1; o.pc_sel = bt;
        exp_q.push_back(o); len++;
      end
      default: begin
        o.err = 1'b1; o.pc_en = 1'b1;
        exp_q.push_back(o); len++;
      end
    endcase
  endtask

  function automatic logic mem_ready_for(input logic [2:0] it, input int n_wait, input int c);
    if ((it == 3'd3 || it == 3'd4) && c >= 1) begin
      if (n_wait == 0)  return 1'b0;
      if (c <= n_wait)  return (c == n_wait);
    end
    return 1'($urandom);
  endfunction

  // Called at posedge+1 with the DUT idle; returns at posedge+1 after the last busy cycle.
  task automatic do_txn(input logic [2:0] it, input logic [3:0] op, input logic [CSR_W-1:0] sel,
                        input logic bt, input int n_wait);
    int len;
    model(it, op, sel, bt, n_wait, len);
    instr_valid  = 1'b1;
    itype        = it;
    instr        = op;
    csr_sel      = sel;
    branch_taken = 1'($urandom);
    mem_ready    = 1'($urandom);
    @(posedge clk); #1;
    for (int c = 0; c < len; c++) begin
      instr_valid  = 1'($urandom);
      itype        = 3'($urandom);
      instr        = 4'($urandom);
      csr_sel      = CSR_W'($urandom);
      branch_taken = (c == 0) ? bt : 1'($urandom);
      mem_ready    = mem_ready_for(it, n_wait, c);
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
  endtask

  task automatic do_reset_in_mem_wait(input logic [2:0] it);
    int len;
    model(it, 4'h7, '0, 1'b0, 0, len);
    instr_valid = 1'b1;
    itype       = it;
    mem_ready   = 1'b0;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin @(posedge clk); #1; end
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_mem_req", 32'(mem_req), 32'd0);
    check("rst_async_instr_ready", 32'(instr_ready), 32'd1);
    check("rst_async_regwrite", 32'(regwrite), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    outs_t act, exp;
    forever begin
      @(negedge clk);
      n_cyc++;
      act = sample();
      if (instr_ready !== 1'b0) begin
        check($sformatf("idle_outputs@%0d", n_cyc), 32'(act), 32'(idle_o));
      end else if (exp_q.size() == 0) begin
        check($sformatf("unexpected_busy@%0d", n_cyc), 32'(act), 32'(idle_o));
      end else begin
        exp = exp_q.pop_front();
        check($sformatf("busy_cycle@%0d", n_cyc), 32'(act), 32'(exp));
      end
    end
  end

  initial begin : driver
    logic [2:0]       r_it;
    logic [3:0]       r_op;
    logic [CSR_W-1:0] r_sel;
    int               r_wait;

    idle_o             = '0;
    idle_o.instr_ready = 1'b1;
    rst_n        = 1'b0;
    instr_valid  = 1'b0;
    itype        = '0;
    instr        = '0;
    csr_sel      = '0;
    branch_taken = 1'b0;
    mem_ready    = 1'b0;
    #3;
    check("reset_outputs", 32'(sample()), 32'(idle_o));
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    do_txn(3'd0, 4'd0,  2'd0, 1'b0, 0);  // R add
    do_txn(3'd0, 4'd13, 2'd1, 1'b0, 0);  // csrrw in range
    do_txn(3'd0, 4'd13, 2'd3, 1'b0, 0);  // csrrw out of range
    do_txn(3'd3, 4'd9,  2'd0, 1'b0, 3);  // load, 3 wait cycles
    do_txn(3'd4, 4'd2,  2'd0, 1'b0, 0);  // store, timeout
    do_txn(3'd4, 4'd2,  2'd0, 1'b0, MT + 1);  // store, ready on the timeout cycle
    do_txn(3'd5, 4'd4,  2'd0, 1'b1, 0);  // branch taken
    do_txn(3'd5, 4'd4,  2'd0, 1'b0, 0);  // branch not taken
    do_txn(3'd7, 4'd0,  2'd0, 1'b0, 0);  // illegal
    do_txn(3'd6, 4'd3,  2'd0, 1'b0, 0);  // illegal
    do_reset_in_mem_wait(3'd3);
    do_txn(3'd1, 4'd5,  2'd0, 1'b0, 0);  // I after reset

    for (int t = 0; t < 200; t++) begin
      r_it   = 3'($urandom_range(0, 7));
      r_op   = (r_it == 3'd0 && $urandom_range(0, 2) == 0) ? 4'd13 : 4'($urandom);
      r_sel  = CSR_W'($urandom);
      r_wait = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4));
      do_txn(r_it, r_op, r_sel, 1'($urandom), r_wait);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
